// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a level-sampled strobe and shifts it
// out LSB first on a registered, idle-high serial line.
module uart_tx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    wire baud_last = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            // NOTE: default-low here, later non-blocking assignments in the same cycle win, so tx_done is a clean one-cycle pulse.
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    tx_busy  <= 1'b0;
                    baud_cnt <= '0;
                    if (tx_start) begin
                        shreg   <= tx_data;
                        state   <= START;
                        txd     <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        txd      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // Next bit is shreg[1] since the shift lands on the same edge.
                            txd     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 4 clocks per bit, with a
// mid-slot sampling reference receiver decoding each frame.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int vectors = 0;
    int miscompares = 0;

    uart_tx #(
        .CLK_FREQ_HZ(8),
        .BAUD_RATE  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .txd     (txd),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("%s txd c%0d", tag, i), 32'(txd), 32'd1);
            check($sformatf("%s busy c%0d", tag, i), 32'(tx_busy), 32'd0);
            check($sformatf("%s done c%0d", tag, i), 32'(tx_done), 32'd0);
        end
    endtask

    // Called #1 after the accepting edge E0; returns #1 after E0+10*CPB.
    // At cycle inj (if >= 0) tx_data is replaced and tx_start raised; with
    // pulse set, tx_start drops again one cycle later.
    task automatic frame_check(input string tag, input logic [7:0] data,
                               input int inj, input logic [7:0] inj_data,
                               input logic pulse);
        logic [9:0] frame;
        logic [7:0] rx;
        frame = {1'b1, data, 1'b0};
        rx = '0;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c > 0) tick();
            if (inj >= 0 && c == inj) begin
                tx_data  = inj_data;
                tx_start = 1'b1;
            end
            if (inj >= 0 && c == inj + 1 && pulse) tx_start = 1'b0;
            check($sformatf("%s txd c%0d", tag, c), 32'(txd), 32'(frame[c / CPB]));
            check($sformatf("%s busy c%0d", tag, c), 32'(tx_busy), 32'd1);
            check($sformatf("%s done c%0d", tag, c), 32'(tx_done), 32'd0);
            if (c % CPB == CPB / 2 && c / CPB >= 1 && c / CPB <= 8)
                rx[c / CPB - 1] = txd;
        end
        tick();
        check({tag, " rx byte"}, 32'(rx), 32'(data));
        check({tag, " end busy"}, 32'(tx_busy), 32'd0);
        check({tag, " end done"}, 32'(tx_done), 32'd1);
        check({tag, " end txd"}, 32'(txd), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #1;
        check("reset txd", 32'(txd), 32'd1);
        check("reset busy", 32'(tx_busy), 32'd0);
        check("reset done", 32'(tx_done), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        idle_check("post reset", 4);

        // Single frame 0xA5: slots 0,1,0,1,0,0,1,0,1,1
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        frame_check("a5", 8'hA5, -1, 8'h00, 1'b0);
        idle_check("a5 idle", 6);

        // Busy ignore: 0xFF strobe at cycle 12 of a 0x00 frame
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        frame_check("ign", 8'h00, 12, 8'hFF, 1'b1);
        idle_check("ign idle", 45);

        // Back-to-back: 0x55 then 0x0F with tx_start held through tx_done
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick();
        frame_check("b2b0", 8'h55, 5, 8'h0F, 1'b0);
        tick();
        frame_check("b2b1", 8'h0F, 0, 8'h0F, 1'b1);
        idle_check("b2b idle", 6);

        // Mid-frame reset during data bit 3 of a 0x00 frame
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (17) tick();
        check("mid bit3 txd", 32'(txd), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst txd", 32'(txd), 32'd1);
        check("async rst busy", 32'(tx_busy), 32'd0);
        check("async rst done", 32'(tx_done), 32'd0);
        tx_start = 1'b1;
        tick();
        check("rst wins busy", 32'(tx_busy), 32'd0);
        check("rst wins txd", 32'(txd), 32'd1);
        tx_start = 1'b0;
        #2;
        rst = 1'b0;
        idle_check("post abort", 45);

        tx_data  = 8'h3C;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        frame_check("3c", 8'h3C, -1, 8'h00, 1'b0);
        idle_check("3c idle", 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
